// File: rtl/poly_stream_reader.sv
// Read-side sequencer for a coefficient RAM: sweeps an address window and streams the
// words out as a registered valid/ready stream, optionally lifted to centered signed form.
module poly_stream_reader #(
   parameter int RAM_WIDTH     = 13,
   parameter int RAM_ADDR_BITS = 11,
   parameter int Q             = 4591
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     center,
   input  logic [RAM_ADDR_BITS-1:0] base_address,
   input  logic [RAM_ADDR_BITS-1:0] length,
   output logic [RAM_ADDR_BITS-1:0] read_address,
   input  logic [RAM_WIDTH-1:0]     mem_data,
   output logic [RAM_WIDTH-1:0]     out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done,
   output logic                     range_error
);

   // Stream handshake: a beat transfers on a rising edge where out_valid and out_ready are
   // both high; out_data/out_last hold steady while out_valid is high and out_ready is low.

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam logic [RAM_WIDTH-1:0]     Q_W  = RAM_WIDTH'(Q);
   localparam logic [RAM_WIDTH-1:0]     HALF = RAM_WIDTH'((Q - 1) / 2);
   localparam logic [RAM_ADDR_BITS-1:0] ONE  = RAM_ADDR_BITS'(1);

   state_t                   state;
   state_t                   state_next;
   logic [RAM_ADDR_BITS-1:0] remaining;
   logic                     center_mode;

   logic                     start_accept;
   logic                     load;
   logic                     handshake;
   logic                     last_handshake;
   logic                     over_range;
   logic [RAM_WIDTH-1:0]     f_value;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      start_accept   = 1'b0;
      load           = 1'b0;
      handshake      = out_valid && out_ready;
      last_handshake = 1'b0;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  start_accept = 1'b1;
                  if (length != '0) begin
                     state_next = STREAM;
                  end
               end
            end
            STREAM: begin
               load           = (!out_valid || out_ready) && (remaining != '0);
               last_handshake = handshake && out_last;
               if (last_handshake) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Out-of-range words are flagged and emitted as read, without centering.
   always_comb begin
      over_range = (mem_data >= Q_W);
      f_value    = mem_data;
      if (center_mode && !over_range && (mem_data > HALF)) begin
         f_value = mem_data - Q_W;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         read_address <= '0;
         remaining    <= '0;
         center_mode  <= 1'b0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         done         <= 1'b0;
         range_error  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else if (start_accept) begin
            read_address <= base_address;
            remaining    <= length;
            center_mode  <= center;
            range_error  <= 1'b0;
            if (length == '0) begin
               done <= 1'b1;
            end
         end else if (load) begin
            out_data     <= f_value;
            out_valid    <= 1'b1;
            out_last     <= (remaining == ONE);
            read_address <= read_address + ONE;
            remaining    <= remaining - ONE;
            if (over_range) begin
               range_error <= 1'b1;
            end
         end else if (state == STREAM && handshake) begin
            out_valid <= 1'b0;
            if (last_handshake) begin
               out_last <= 1'b0;
               done     <= 1'b1;
            end
         end
      end
   end

   assign busy = (state == STREAM);

endmodule

// File: tb/tb_poly_stream_reader.sv
// Bench for poly_stream_reader: RAM model, randomized sweeps, and a scoreboard fed by a
// reference model of the address window and centering rules.
module tb_poly_stream_reader;

   localparam int W  = 13;
   localparam int AW = 11;
   localparam int Q  = 4591;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic          center;
   logic [AW-1:0] base_address;
   logic [AW-1:0] length;
   logic [AW-1:0] read_address;
   logic [W-1:0]  mem_data;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          range_error;

   logic [W-1:0]  mem [0:2047];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int beat_no = 0;
   int hs_count = 0;
   int ready_mode = 0;
   int rcnt = 0;
   bit timing_on = 0;
   bit exp_range = 0;

   // {care_data, last, data}
   logic [W+1:0] exp_q[$];

   bit           held_v = 0;
   logic [W-1:0] held_d;
   logic         held_l;
   logic [AW-1:0] held_a;

   poly_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AW), .Q(Q)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .center       (center),
      .base_address (base_address),
      .length       (length),
      .read_address (read_address),
      .mem_data     (mem_data),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .busy         (busy),
      .done         (done),
      .range_error  (range_error)
   );

   assign mem_data = mem[read_address];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   function automatic int f_model(input int x, input bit c);
      if (c && x < Q && x > (Q - 1) / 2) return (x - Q + (1 << W)) % (1 << W);
      return x;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic start_sweep(input int b, input int l, input bit c);
      int x;
      exp_range = 0;
      for (int i = 0; i < l; i++) begin
         x = int'(mem[(b + i) % 2048]);
         if (x >= Q) exp_range = 1;
         exp_q.push_back({(c && x >= Q) ? 1'b0 : 1'b1, (i == l - 1) ? 1'b1 : 1'b0, W'(f_model(x, c))});
      end
      base_address = AW'(b);
      length       = AW'(l);
      center       = c;
      start        = 1'b1;
      start_cyc    = cyc;
      beat_no      = 0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input int exp_cycle);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", int'(done), 1);
      if (done) begin
         check("busy_at_done", int'(busy), 0);
         if (exp_cycle >= 0) check("done_cycle", cyc - start_cyc, exp_cycle);
         check("queue_drained", exp_q.size(), 0);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_read_address"}, int'(read_address), 0);
      check({tag, "_out_data"}, int'(out_data), 0);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_out_last"}, int'(out_last), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_range_error"}, int'(range_error), 0);
   endtask

   // ---------------- ready driver ----------------
   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         rcnt++;
         case (ready_mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = (rcnt % 3 == 0);
            default: out_ready = 1'b1;
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [W+1:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (reset || abort) begin
            held_v = 0;
         end else begin
            if (held_v) begin
               check("stall_valid", int'(out_valid), 1);
               check("stall_data", int'(out_data), int'(held_d));
               check("stall_last", int'(out_last), int'(held_l));
               check("stall_addr", int'(read_address), int'(held_a));
            end
            if (out_valid && out_ready) begin
               hs_count++;
               if (exp_q.size() == 0) begin
                  check("extra_beat", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  if (e[W+1]) check("beat_data", int'(out_data), int'(e[W-1:0]));
                  check("beat_last", int'(out_last), int'(e[W]));
                  if (timing_on) check("beat_cycle", cyc - start_cyc, beat_no + 2);
                  beat_no++;
               end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            held_a = read_address;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int b;
      int l;
      bit c;
      reset = 1'b1; start = 1'b0; abort = 1'b0; center = 1'b0;
      base_address = '0; length = '0;
      for (int a = 0; a < 2048; a++) mem[a] = W'(a % Q);
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      @(negedge clk);

      // full 761-coefficient sweep with exact timing
      timing_on = 1; hs_count = 0;
      start_sweep(0, 761, 1'b0);
      wait_done(800, 763);
      timing_on = 0;
      check("sweep_handshakes", hs_count, 761);
      check("sweep_range_error", int'(range_error), 0);

      // centering and sticky range error
      mem[500] = 13'd0; mem[501] = 13'd2295; mem[502] = 13'd2296; mem[503] = 13'd4590;
      mem[504] = 13'd4600;
      start_sweep(500, 4, 1'b1);
      wait_done(50, 6);
      check("center_range_error", int'(range_error), 0);
      start_sweep(504, 1, 1'b1);
      wait_done(20, 3);
      check("range_error_set", int'(range_error), 1);
      repeat (5) @(negedge clk);
      check("range_error_sticky", int'(range_error), 1);
      start_sweep(0, 2, 1'b0);
      check("range_error_cleared", int'(range_error), 0);
      wait_done(20, 4);

      // backpressure with address wrap
      ready_mode = 2; hs_count = 0;
      start_sweep(2046, 4, 1'b0);
      wait_done(100, -1);
      check("wrap_handshakes", hs_count, 4);
      ready_mode = 0;

      // zero length
      start_sweep(5, 0, 1'b0);
      wait_done(5, 1);
      @(negedge clk);
      check("zero_len_done_once", int'(done), 0);
      check("zero_len_busy", int'(busy), 0);

      // abort on the 10th beat
      start_sweep(0, 761, 1'b0);
      n = 0;
      while (cyc - start_cyc != 11 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("abort_reach", cyc - start_cyc, 11);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      exp_q.delete();
      check("abort_valid", int'(out_valid), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_last", int'(out_last), 0);
      check("abort_addr_held", int'(read_address), 10);
      for (int i = 0; i < 4; i++) begin
         check("abort_no_done", int'(done), 0);
         @(negedge clk);
      end
      start_sweep(100, 3, 1'b0);
      wait_done(20, 5);

      // reset during a sweep
      start_sweep(200, 50, 1'b0);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      exp_q.delete();
      check_reset_values("midreset");
      reset = 1'b0;
      @(negedge clk);

      // randomized sweeps under random backpressure, with a start issued while busy
      ready_mode = 1;
      for (int it = 0; it < 8; it++) begin
         b = int'($urandom_range(0, 2047));
         l = int'($urandom_range(2, 40));
         c = 1'($urandom_range(0, 1));
         for (int i = 0; i < l; i++) begin
            mem[(b + i) % 2048] = ($urandom_range(0, 7) == 0) ? W'($urandom_range(Q, 8191))
                                                              : W'($urandom_range(0, Q - 1));
         end
         start_sweep(b, l, c);
         base_address = AW'($urandom_range(0, 2047));
         length       = AW'($urandom_range(1, 2047));
         start        = 1'b1;
         @(negedge clk);
         start = 1'b0;
         wait_done(400, -1);
         check("random_range_error", int'(range_error), int'(exp_range));
      end
      ready_mode = 0;
      repeat (3) @(negedge clk);
      check("final_idle_busy", int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
